// File: rtl/fifo_head_ctrl_pkg.sv
// Shared FIFO constants: geometry plus the head and tail pointer state encodings.
package fifo_head_ctrl_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;

  typedef enum logic [1:0] {
    H0 = 2'b00,
    H1 = 2'b01,
    H2 = 2'b10,
    H3 = 2'b11
  } head_state_e;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } tail_state_e;

  // H3 wraps straight back to H0 so the pointer never stalls on wrap.
  function automatic head_state_e head_next(input head_state_e cur);
    head_state_e nxt;
    case (cur)
      H0:      nxt = H1;
      H1:      nxt = H2;
      H2:      nxt = H3;
      H3:      nxt = H0;
      default: nxt = H0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_occ_cnt.sv
// Occupancy counter for the 4-entry FIFO; full/empty are decoded from the count flop.
module fifo_occ_cnt
  import fifo_head_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_W = FIFO_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [PTR_W:0]   occupancy,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] ZERO_CNT = (PTR_W + 1)'(0);

  logic [PTR_W:0] occ_d;
  logic [PTR_W:0] occ_q;

  // No saturation: the caller only asserts inc/dec when the move is legal.
  always_comb begin
    occ_d = occ_q;
    if (inc && !dec) begin
      occ_d = occ_q + ONE_CNT;
    end else if (dec && !inc) begin
      occ_d = occ_q - ONE_CNT;
    end else begin
      occ_d = occ_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= ZERO_CNT;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign full      = (occ_q == FULL_CNT);
  assign empty     = (occ_q == ZERO_CNT);

endmodule

// File: rtl/fifo_head_ctrl.sv
// Read-side (head) controller of a 4-entry FIFO: head pointer FSM, occupancy and sticky errors.
module fifo_head_ctrl
  import fifo_head_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_W = FIFO_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in_valid,
  input  logic             data_out_ready,
  output logic [PTR_W-1:0] curr_head,
  output logic [PTR_W:0]   occupancy,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             data_out_valid,
  output logic             err_ovf,
  output logic             err_udf
);

  head_state_e head_d;
  head_state_e head_q;
  logic        err_ovf_d;
  logic        err_ovf_q;
  logic        err_udf_d;
  logic        err_udf_q;
  logic        wr_acc;
  logic        rd_acc;
  logic        occ_full;
  logic        occ_empty;

  // Full read priority falls out of the gating: when full only the read is taken.
  assign wr_acc = data_in_valid & ~occ_full;
  assign rd_acc = data_out_ready & ~occ_empty;

  fifo_occ_cnt #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_occ_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (wr_acc & ~rd_acc),
    .dec       (rd_acc & ~wr_acc),
    .occupancy (occupancy),
    .full      (occ_full),
    .empty     (occ_empty)
  );

  // Head advance and sticky error accumulation.
  always_comb begin
    head_d    = head_q;
    err_ovf_d = err_ovf_q | (data_in_valid & occ_full);
    err_udf_d = err_udf_q | (data_out_ready & occ_empty);
    if (rd_acc) begin
      head_d = head_next(head_q);
    end else begin
      head_d = head_q;
    end
  end

  // Head state and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= H0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign curr_head      = head_q;
  assign fifo_full      = occ_full;
  assign fifo_empty     = occ_empty;
  assign data_out_valid = ~occ_empty;
  assign err_ovf        = err_ovf_q;
  assign err_udf        = err_udf_q;

endmodule

// File: tb/tb_fifo_head_ctrl.sv
// Scoreboard bench for fifo_head_ctrl: reference model of head/occupancy plus a data queue through a model storage array.
module tb_fifo_head_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in_valid;
  logic       data_out_ready;
  logic [1:0] curr_head;
  logic [2:0] occupancy;
  logic       fifo_full;
  logic       fifo_empty;
  logic       data_out_valid;
  logic       err_ovf;
  logic       err_udf;

  typedef struct packed {
    logic [2:0] occ;
    logic [1:0] head;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] data_q[$];
  logic [7:0] mem [4];
  int         m_occ, m_head, m_tail;
  logic       m_ovf, m_udf;
  int         n_chk = 0;
  int         n_pass = 0;

  fifo_head_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_valid  (data_in_valid),
    .data_out_ready (data_out_ready),
    .curr_head      (curr_head),
    .occupancy      (occupancy),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .data_out_valid (data_out_valid),
    .err_ovf        (err_ovf),
    .err_udf        (err_udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_head"},  32'(curr_head), 32'd0);
    check({tag, "_occ"},   32'(occupancy), 32'd0);
    check({tag, "_full"},  32'(fifo_full), 32'd0);
    check({tag, "_empty"}, 32'(fifo_empty), 32'd1);
    check({tag, "_dov"},   32'(data_out_valid), 32'd0);
    check({tag, "_ovf"},   32'(err_ovf), 32'd0);
    check({tag, "_udf"},   32'(err_udf), 32'd0);
  endtask

  task automatic model_clear();
    m_occ = 0; m_head = 0; m_tail = 0; m_ovf = 1'b0; m_udf = 1'b0;
    exp_q.delete();
    data_q.delete();
  endtask

  task automatic step(input logic wv, input logic rv);
    exp_t       e;
    logic       wr, rd;
    logic [7:0] wd;
    @(negedge clk);
    data_in_valid  = wv;
    data_out_ready = rv;
    wr = wv && (m_occ != 4);
    rd = rv && (m_occ != 0);
    #1;
    if (rd) check("rd_data", 32'(mem[curr_head]), 32'(data_q.pop_front()));
    wd = 8'($urandom);
    if (wv && !fifo_full) begin
      mem[m_tail] = wd;
      m_tail = (m_tail + 1) % 4;
    end
    if (wr) data_q.push_back(wd);
    m_ovf  = m_ovf | (wv && m_occ == 4);
    m_udf  = m_udf | (rv && m_occ == 0);
    m_occ  = m_occ + int'(wr) - int'(rd);
    m_head = rd ? (m_head + 1) % 4 : m_head;
    e.occ = 3'(m_occ); e.head = 2'(m_head); e.ovf = m_ovf; e.udf = m_udf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("occ",   32'(occupancy), 32'(e.occ));
    check("head",  32'(curr_head), 32'(e.head));
    check("full",  32'(fifo_full), 32'(e.occ == 3'd4));
    check("empty", 32'(fifo_empty), 32'(e.occ == 3'd0));
    check("dov",   32'(data_out_valid), 32'(e.occ != 3'd0));
    check("ovf",   32'(err_ovf), 32'(e.ovf));
    check("udf",   32'(err_udf), 32'(e.udf));
    check("inv",   32'((m_tail - int'(curr_head)) & 3), 32'(int'(occupancy) & 3));
  endtask

  initial begin
    rst = 1'b1;
    data_in_valid = 1'b0;
    data_out_ready = 1'b0;
    model_clear();
    #12;
    check_reset_values("rst0");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("full_after_4wr", 32'(fifo_full), 32'd1);
    check("head_after_4wr", 32'(curr_head), 32'd0);

    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("ovf_sticky", 32'(err_ovf), 32'd1);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    check("empty_after_4rd", 32'(fifo_empty), 32'd1);

    step(1'b1, 1'b1);
    check("rw_empty_occ", 32'(occupancy), 32'd1);
    check("rw_empty_udf", 32'(err_udf), 32'd1);

    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    check("rw_occ2_occ", 32'(occupancy), 32'd2);

    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("pre_rst_occ", 32'(occupancy), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("rst_async");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    data_in_valid = 1'b0;
    data_out_ready = 1'b0;

    step(1'b1, 1'b0);
    check("post_rst_first_wr", 32'(occupancy), 32'd1);

    for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
